dma_fifo_bank: RTL and testbench
================================

// Module: dma_fifo_bank
// PURPOSE
//  Parametrised per-channel FIFO bank between the DMA bus engine and the channel arbiter.
//  Holds N_CH independent FIFOs in packed-vector form, with per-channel clear/write/read.
//  Adds occupancy level, almost-full watermark and simultaneous read/write at full.
//  Optionally adds sticky overflow/underflow error flags.
// PARAMETERS
//  N_CH       4    number of channels (1..16)
//  DW         32   data width per channel
//  DEPTH      16   entries per channel; power of two, >=2; AW = $clog2(DEPTH)
//  AF_THRESH  12   afull[i] asserted when level_i >= AF_THRESH (1..DEPTH)
// PORTS
//  clk     in   1          clock, all logic rising-edge
//  rst     in   1          synchronous reset, active-high
//  clr     in   N_CH       per-channel synchronous flush
//  wr      in   N_CH       per-channel write request
//  rd      in   N_CH       per-channel read request
//  wdata   in   N_CH*DW    channel i at [i*DW +: DW]
//  rdata   out  N_CH*DW    channel i at [i*DW +: DW], registered
//  full    out  N_CH       level_i == DEPTH
//  empty   out  N_CH       level_i == 0
//  afull   out  N_CH       level_i >= AF_THRESH
//  level   out  N_CH*(AW+1) occupancy, channel i at [i*(AW+1) +: AW+1]
//  err_clr in   1          clears all sticky error flags (only used with DMA_FIFO_ERR_EN)
//  ovf     out  N_CH       sticky overflow flag
//  udf     out  N_CH       sticky underflow flag
// BEHAVIOUR
//  Clocking and reset
//  - One clock, clk. Reset rst is synchronous and active-high.
//  - Reset: pointers=0, level=0, empty=1, full=0, afull=0, rdata=0, ovf=0, udf=0.
//  - Channels are fully independent; no cross-channel interaction.
//  Per-channel accept rules (evaluated on the same cycle)
//  - rd_ok = rd & !empty.
//  - wr_ok = wr & (!full | rd_ok). Read and write at full both succeed; level stays DEPTH.
//  - At empty, rd is dropped even with a simultaneous wr. There is no fall-through.
//  Read timing
//  - On rd_ok, rdata shows the head entry on the next cycle (1-cycle latency).
//  - rdata holds its last value otherwise, including after clr.
//  Pointers and level
//  - Pointers are AW bits and wrap naturally DEPTH-1 -> 0.
//  - level (AW+1 bits) is +1 on wr_ok only, -1 on rd_ok only, unchanged when both.
//  - full, empty and afull are registered, derived from next-state level, so they are
//    valid in the same cycle level updates.
//  Clear
//  - clr has priority over rd/wr in that cycle. Both are ignored; pointers and level go to 0.
//  - ovf/udf are not touched by clr.
//  Reset mid-operation
//  - Reset overrides everything. Stored data is not cleared; it is unreachable.
// CONFIGURATION
//  DMA_FIFO_ERR_EN defined
//  - ovf[i] sets on wr & !wr_ok & !clr[i]; udf[i] sets on rd & empty & !clr[i].
//  - Both are sticky until rst or err_clr. If err_clr and a set event coincide, the set wins.
//  DMA_FIFO_ERR_EN undefined
//  - ovf and udf are tied to 0, err_clr is ignored, and no error logic is synthesised.
//  - The port list is identical in both builds.
// STRUCTURE
//  - Shared header dma_pkg: DMA_DW, DMA_N_CH, DMA_FIFO_DEPTH defaults and the
//    clog2 function/macro.
//  - Sub-module dma_fifo_ch: one channel holding storage, pointers, level, flags and
//    error logic.
//  - dma_fifo_bank: generate loop of N_CH dma_fifo_ch instances plus vector slicing.
// TESTING (defaults N_CH=4, DW=32, DEPTH=16, AF_THRESH=12)
//  1. rst, then 16 writes ch0 of 0x100+k -> full[0]=1, level0=16, afull[0] from 12th write;
//     16 reads return 0x100..0x10F in order, each 1 cycle after rd.
//  2. ch1 full, then rd+wr 0xAA for 3 cycles -> level1 stays 16, no ovf;
//     the data order preserves 0xAA after the original 16 entries.
//  3. ch2 empty, rd+wr 0x55 -> rd dropped, level2=1, udf[2]=1 (ERR_EN), rdata unchanged.
//  4. ch3 level 7, clr[3] with wr[3] -> level3=0, empty[3]=1; ch0..2 unaffected.
//  5. 20 writes to ch0 (wrap past 15), then 40 interleaved rd/wr -> data in order.
//  6. ERR_EN: ovf[0] set by wr at full, held over 10 idle cycles, cleared by err_clr;
//     ERR_EN undefined: same stimulus -> ovf=0.

Source files
------------

// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared defaults for the DMA FIFO bank and a constant-evaluable ceil(log2)
// helper used to size pointers and occupancy counters.
// No ports; imported by dma_fifo_ch and dma_fifo_bank.
// -----------------------------------------------------------------------------
package dma_pkg;

    localparam int DMA_DW             = 32;
    localparam int DMA_N_CH           = 4;
    localparam int DMA_FIFO_DEPTH     = 16;
    localparam int DMA_FIFO_AF_THRESH = 12;

    // Number of address bits needed to index 'value' entries.
    function automatic int dma_clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/dma_fifo_ch.sv
// -----------------------------------------------------------------------------
// dma_fifo_ch
// One independent FIFO channel: storage, pointers, occupancy level, registered
// status flags and a registered read-data port with one cycle of latency.
// Optional feature macro: DMA_FIFO_ERR_EN adds sticky overflow/underflow flags;
// without it ovf/udf are tied low and err_clr is ignored.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clr           synchronous flush (priority over rd/wr)
//   wr, wdata     write request and data
//   rd, rdata     read request and registered head data
//   full, empty, afull, level   registered status
//   err_clr       clears sticky error flags
//   ovf, udf      sticky overflow / underflow flags
// -----------------------------------------------------------------------------
module dma_fifo_ch
    import dma_pkg::*;
#(
    parameter int  DW        = DMA_DW,
    parameter int  DEPTH     = DMA_FIFO_DEPTH,
    parameter int  AF_THRESH = DMA_FIFO_AF_THRESH,
    localparam int AW        = dma_clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr,
    input  logic          rd,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic          afull,
    output logic [AW:0]   level,
    input  logic          err_clr,
    output logic          ovf,
    output logic          udf
);

    localparam int LW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rd_ok, wr_ok, rd_en, wr_en;

    // A read at full frees a slot in the same cycle, so a simultaneous write
    // is accepted. Flags come from the next-state level so they line up with
    // the level output.
    always_comb begin
        rd_ok    = rd & ~empty_q;
        wr_ok    = wr & (~full_q | rd_ok);
        rd_en    = rd_ok & ~clr;
        wr_en    = wr_ok & ~clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rdata_d  = rdata_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                rdata_d  = mem_q[rd_ptr_q];
            end
            if (wr_en && !rd_en) begin
                level_d = level_q + LW'(1);
            end else if (rd_en && !wr_en) begin
                level_d = level_q - LW'(1);
            end
        end
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
        afull_d = (level_d >= LW'(AF_THRESH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage is never reset; after reset or clr old entries are simply
    // unreachable because the pointers restart at zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = rdata_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign afull = afull_q;
    assign level = level_q;

`ifdef DMA_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Set events beat err_clr when they coincide; clr suppresses set events.
    always_comb begin
        ovf_d = err_clr ? 1'b0 : ovf_q;
        udf_d = err_clr ? 1'b0 : udf_q;
        if (wr && !wr_ok && !clr) begin
            ovf_d = 1'b1;
        end
        if (rd && empty_q && !clr) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule

// File: rtl/dma_fifo_bank.sv
// -----------------------------------------------------------------------------
// dma_fifo_bank
// N_CH independent FIFOs between the DMA bus engine and the channel arbiter,
// exposed as packed vectors (channel i occupies slice i of every vector).
// Optional feature macro: DMA_FIFO_ERR_EN (sticky ovf/udf flags per channel).
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   clr, wr, rd         per-channel flush / write / read requests
//   wdata, rdata        N_CH*DW data, rdata registered
//   full, empty, afull  per-channel status
//   level               N_CH*(AW+1) occupancy
//   err_clr, ovf, udf   error flag clear and sticky flags
// -----------------------------------------------------------------------------
module dma_fifo_bank
    import dma_pkg::*;
#(
    parameter int  N_CH      = DMA_N_CH,
    parameter int  DW        = DMA_DW,
    parameter int  DEPTH     = DMA_FIFO_DEPTH,
    parameter int  AF_THRESH = DMA_FIFO_AF_THRESH,
    localparam int AW        = dma_clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        clr,
    input  logic [N_CH-1:0]        wr,
    input  logic [N_CH-1:0]        rd,
    input  logic [N_CH*DW-1:0]     wdata,
    output logic [N_CH*DW-1:0]     rdata,
    output logic [N_CH-1:0]        full,
    output logic [N_CH-1:0]        empty,
    output logic [N_CH-1:0]        afull,
    output logic [N_CH*(AW+1)-1:0] level,
    input  logic                   err_clr,
    output logic [N_CH-1:0]        ovf,
    output logic [N_CH-1:0]        udf
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        dma_fifo_ch #(
            .DW        (DW),
            .DEPTH     (DEPTH),
            .AF_THRESH (AF_THRESH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr[i]),
            .wr      (wr[i]),
            .rd      (rd[i]),
            .wdata   (wdata[i*DW +: DW]),
            .rdata   (rdata[i*DW +: DW]),
            .full    (full[i]),
            .empty   (empty[i]),
            .afull   (afull[i]),
            .level   (level[i*(AW+1) +: AW+1]),
            .err_clr (err_clr),
            .ovf     (ovf[i]),
            .udf     (udf[i])
        );
    end

endmodule

// File: tb/tb_dma_fifo_bank.sv
// -----------------------------------------------------------------------------
// tb_dma_fifo_bank
// Directed bench for dma_fifo_bank at default parameters. Stimulus pushes the
// data each accepted read must return into a per-channel queue; an independent
// monitor pops and compares one cycle after every accepted read.
// Honours DMA_FIFO_ERR_EN for the expected ovf/udf values.
// -----------------------------------------------------------------------------
module tb_dma_fifo_bank;

    localparam int N_CH  = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

`ifdef DMA_FIFO_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic [N_CH-1:0]     clr, wr, rd;
    logic [N_CH*DW-1:0]  wdata, rdata;
    logic [N_CH-1:0]     full, empty, afull;
    logic [N_CH*LW-1:0]  level;
    logic                err_clr;
    logic [N_CH-1:0]     ovf, udf;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q [N_CH][$];
    logic [DW-1:0] exp_q   [N_CH][$];

    dma_fifo_bank dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wr      (wr),
        .rd      (rd),
        .wdata   (wdata),
        .rdata   (rdata),
        .full    (full),
        .empty   (empty),
        .afull   (afull),
        .level   (level),
        .err_clr (err_clr),
        .ovf     (ovf),
        .udf     (udf)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle of requests, updating the reference FIFO contents with
    // the accept rules and queueing the data every accepted read must return.
    task automatic applyStimulus(input logic [N_CH-1:0] w, input logic [N_CH-1:0] r,
                                 input logic [N_CH-1:0] c, input logic ec,
                                 input logic [DW-1:0] d);
        for (int ch = 0; ch < N_CH; ch++) begin
            int  lvl;
            bit  rdok, wrok;
            lvl  = model_q[ch].size();
            rdok = r[ch] && (lvl != 0);
            wrok = w[ch] && ((lvl != DEPTH) || rdok);
            if (c[ch]) begin
                model_q[ch].delete();
            end else begin
                if (rdok) exp_q[ch].push_back(model_q[ch].pop_front());
                if (wrok) model_q[ch].push_back(d);
            end
        end
        wr      = w;
        rd      = r;
        clr     = c;
        err_clr = ec;
        wdata   = {N_CH{d}};
        @(posedge clk);
        #1;
        wr      = '0;
        rd      = '0;
        clr     = '0;
        err_clr = 1'b0;
    endtask

    function automatic logic [31:0] lvl(input int ch);
        return 32'(level[ch*LW +: LW]);
    endfunction

    function automatic logic [31:0] rdat(input int ch);
        return rdata[ch*DW +: DW];
    endfunction

    // Monitor: a read presented while the channel is not empty and not being
    // cleared must deliver the queued head on the following cycle.
    initial begin
        logic [N_CH-1:0] fire;
        forever begin
            @(posedge clk);
            fire = rst ? '0 : (rd & ~empty & ~clr);
            @(negedge clk);
            for (int ch = 0; ch < N_CH; ch++) begin
                if (fire[ch]) begin
                    if (exp_q[ch].size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL sb_underrun ch%0d: got read data %0h expected no read", ch, rdat(ch));
                    end else begin
                        checkOutput($sformatf("rdata ch%0d", ch), rdat(ch), exp_q[ch].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; clr = '0; wr = '0; rd = '0; wdata = '0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("rst level", 32'(level), 0);
        checkOutput("rst empty", 32'(empty), 32'hF);
        checkOutput("rst full", 32'(full), 0);
        checkOutput("rst afull", 32'(afull), 0);
        checkOutput("rst rdata", rdata[31:0] | rdata[63:32] | rdata[95:64] | rdata[127:96], 0);
        checkOutput("rst ovf", 32'(ovf), 0);
        checkOutput("rst udf", 32'(udf), 0);

        $display("[TB] ch0 fill and drain");
        for (int k = 0; k < 16; k++) begin
            applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b0, 32'h100 + 32'(k));
            checkOutput("t1 level0", lvl(0), 32'(k + 1));
            checkOutput("t1 afull0", 32'(afull[0]), (k + 1 >= 12) ? 32'd1 : 32'd0);
        end
        checkOutput("t1 full0", 32'(full[0]), 1);
        for (int k = 0; k < 16; k++) applyStimulus(4'b0000, 4'b0001, 4'b0000, 1'b0, 32'h0);
        checkOutput("t1 empty0", 32'(empty[0]), 1);

        $display("[TB] ch1 read+write at full");
        for (int k = 0; k < 16; k++) applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0, 32'h200 + 32'(k));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b0, 32'hAA);
            checkOutput("t2 level1", lvl(1), 16);
            checkOutput("t2 full1", 32'(full[1]), 1);
        end
        checkOutput("t2 ovf1", 32'(ovf[1]), 0);
        for (int k = 0; k < 16; k++) applyStimulus(4'b0000, 4'b0010, 4'b0000, 1'b0, 32'h0);
        checkOutput("t2 empty1", 32'(empty[1]), 1);

        $display("[TB] ch2 read+write at empty");
        applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b0, 32'h55);
        checkOutput("t3 level2", lvl(2), 1);
        checkOutput("t3 udf2", 32'(udf[2]), 32'(ERR));
        checkOutput("t3 rdata2", rdat(2), 0);

        $display("[TB] ch3 clear with write");
        for (int k = 0; k < 7; k++) applyStimulus(4'b1000, 4'b0000, 4'b0000, 1'b0, 32'h300 + 32'(k));
        checkOutput("t4 level3 pre", lvl(3), 7);
        applyStimulus(4'b1000, 4'b0000, 4'b1000, 1'b0, 32'h3FF);
        checkOutput("t4 level3", lvl(3), 0);
        checkOutput("t4 empty3", 32'(empty[3]), 1);
        checkOutput("t4 rdata3", rdat(3), 0);
        checkOutput("t4 level2", lvl(2), 1);
        checkOutput("t4 level01", lvl(0) | lvl(1), 0);
        checkOutput("t4 udf2 kept", 32'(udf[2]), 32'(ERR));
        applyStimulus(4'b0000, 4'b0100, 4'b0000, 1'b0, 32'h0);

        $display("[TB] ch0 wrap and interleave");
        for (int k = 0; k < 12; k++) applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b0, 32'h400 + 32'(k));
        for (int k = 0; k < 8; k++) applyStimulus(4'b0000, 4'b0001, 4'b0000, 1'b0, 32'h0);
        for (int k = 0; k < 8; k++) applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b0, 32'h40C + 32'(k));
        checkOutput("t5 level0 wrap", lvl(0), 12);
        for (int k = 0; k < 40; k++) applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0, 32'h500 + 32'(k));
        checkOutput("t5 level0 steady", lvl(0), 12);
        for (int k = 0; k < 12; k++) applyStimulus(4'b0000, 4'b0001, 4'b0000, 1'b0, 32'h0);
        checkOutput("t5 empty0", 32'(empty[0]), 1);
        checkOutput("t5 ovf0", 32'(ovf[0]), 0);

        $display("[TB] ch0 overflow flag");
        for (int k = 0; k < 16; k++) applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b0, 32'h600 + 32'(k));
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b0, 32'h6FF);
        checkOutput("t6 ovf0 set", 32'(ovf[0]), 32'(ERR));
        checkOutput("t6 level0", lvl(0), 16);
        for (int k = 0; k < 10; k++) applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0);
        checkOutput("t6 ovf0 held", 32'(ovf[0]), 32'(ERR));
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0);
        checkOutput("t6 ovf0 cleared", 32'(ovf[0]), 0);
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b1, 32'h6FE);
        checkOutput("t6 set beats clear", 32'(ovf[0]), 32'(ERR));
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1, 32'h0);
        checkOutput("t6 udf cleared", 32'(udf), 0);
        for (int k = 0; k < 16; k++) applyStimulus(4'b0000, 4'b0001, 4'b0000, 1'b0, 32'h0);
        checkOutput("t6 empty0", 32'(empty[0]), 1);

        @(posedge clk);
        #1;
        for (int ch = 0; ch < N_CH; ch++) begin
            checkOutput($sformatf("sb drained ch%0d", ch), 32'(exp_q[ch].size()), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
